rob_tag_alloc: RTL and testbench

Allocator and commit sequencer for the 5-bit reorder tags used by the register alias table. It hands out up to two fresh tags per cycle at dispatch and tracks completion from the four writeback ports (INT1, INT2, MUL, LW). It drives the in-order commit pointer and the two commit enables, and raises stall when tag space runs out.

---
 rtl/rob_tag_alloc_pkg.sv | 12 +
 rtl/rob_ready_bits.sv | 69 ++++++
 rtl/rob_tag_alloc.sv | 109 ++++++++++
 tb/tb_rob_tag_alloc.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rob_tag_alloc_pkg.sv
// Shared reorder-tag definitions used by the tag allocator, RAT and dispatch.
package rob_tag_alloc_pkg;

  localparam int unsigned TAG_W  = 5;
  localparam int unsigned DEPTH  = 32;
  localparam int unsigned OCC_W  = TAG_W + 1;
  localparam int unsigned NUM_WB = 4;

  typedef logic [TAG_W-1:0] tag_t;
  typedef logic [OCC_W-1:0] occ_t;

endpackage

// File: rtl/rob_ready_bits.sv
// Per-tag live/ready bit array: 2 allocate, 4 writeback, 2 clear, 2 read ports.
module rob_ready_bits
  import rob_tag_alloc_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         alloc_en1,
  input  tag_t                         alloc_tag1,
  input  logic                         alloc_en2,
  input  tag_t                         alloc_tag2,
  input  logic [NUM_WB-1:0]            wb_en,
  input  logic [NUM_WB-1:0][TAG_W-1:0] wb_tag,
  input  logic                         clr_en1,
  input  tag_t                         clr_tag1,
  input  logic                         clr_en2,
  input  tag_t                         clr_tag2,
  input  tag_t                         rd_tag1,
  input  tag_t                         rd_tag2,
  output logic                         rd_rdy1_c,
  output logic                         rd_rdy2_c
);

  logic [DEPTH-1:0] live, rdy, live_nxt, rdy_nxt;

  // Writebacks only land on live tags; clears beat writebacks, allocation and flush win last.
  always_comb begin
    live_nxt = live;
    rdy_nxt  = rdy;
    for (int unsigned i = 0; i < NUM_WB; i++) begin
      if (wb_en[i] && live[wb_tag[i]]) rdy_nxt[wb_tag[i]] = 1'b1;
    end
    if (clr_en1) begin
      live_nxt[clr_tag1] = 1'b0;
      rdy_nxt[clr_tag1]  = 1'b0;
    end
    if (clr_en2) begin
      live_nxt[clr_tag2] = 1'b0;
      rdy_nxt[clr_tag2]  = 1'b0;
    end
    if (alloc_en1) begin
      live_nxt[alloc_tag1] = 1'b1;
      rdy_nxt[alloc_tag1]  = 1'b0;
    end
    if (alloc_en2) begin
      live_nxt[alloc_tag2] = 1'b1;
      rdy_nxt[alloc_tag2]  = 1'b0;
    end
    if (flush) begin
      live_nxt = '0;
      rdy_nxt  = '0;
    end
  end

  // Bit array state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      live <= '0;
      rdy  <= '0;
    end else begin
      live <= live_nxt;
      rdy  <= rdy_nxt;
    end
  end

  assign rd_rdy1_c = rdy[rd_tag1];
  assign rd_rdy2_c = rdy[rd_tag2];

endmodule

// File: rtl/rob_tag_alloc.sv
// Reorder tag allocator and in-order commit sequencer.
// Optional: define ROB_STALL_CNT_EN to add a saturating stall_cnt output.
module rob_tag_alloc
  import rob_tag_alloc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        alloc_req1,
  input  logic        alloc_req2,
  output tag_t        new_tag1,
  output tag_t        new_tag2,
  output logic        stall,
  input  logic        we_INT1,
  input  logic        we_INT2,
  input  logic        we_MUL,
  input  logic        we_LW,
  input  tag_t        INT_tag1,
  input  tag_t        INT_tag2,
  input  tag_t        MUL_tag,
  input  tag_t        LW_tag,
  output tag_t        C_p,
  output logic        C_we1,
  output logic        C_we2,
  output occ_t        occ
`ifdef ROB_STALL_CNT_EN
  ,
  output logic [15:0] stall_cnt
`endif
);

  tag_t       head, tail, head_p1;
  occ_t       free_slots;
  logic [1:0] need, granted, committed;
  logic       grant1, grant2, rdy_head, rdy_head_p1;

  assign head_p1 = head + tag_t'(1);
  assign C_p     = head;

  // Dispatch side: stall uses only registered occupancy, ignoring same-cycle commits.
  always_comb begin
    need       = 2'(alloc_req1) + 2'(alloc_req2);
    free_slots = occ_t'(DEPTH) - occ;
    stall      = flush | (free_slots < occ_t'(need));
    grant1     = ~stall & alloc_req1;
    grant2     = ~stall & alloc_req2;
    granted    = stall ? 2'd0 : need;
    new_tag1   = tail;
    new_tag2   = tail + tag_t'(alloc_req1);
  end

  // Commit side: retire up to two ready tags from the head, suppressed by flush.
  always_comb begin
    C_we1     = ~flush & (occ != '0) & rdy_head;
    C_we2     = C_we1 & (occ >= occ_t'(2)) & rdy_head_p1;
    committed = 2'(C_we1) + 2'(C_we2);
  end

  // Head/tail pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
    end else if (flush) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
    end else begin
      head <= head + tag_t'(committed);
      tail <= tail + tag_t'(granted);
      occ  <= occ + occ_t'(granted) - occ_t'(committed);
    end
  end

  rob_ready_bits u_bits (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .alloc_en1  (grant1),
    .alloc_tag1 (new_tag1),
    .alloc_en2  (grant2),
    .alloc_tag2 (new_tag2),
    .wb_en      ({we_LW, we_MUL, we_INT2, we_INT1}),
    .wb_tag     ({LW_tag, MUL_tag, INT_tag2, INT_tag1}),
    .clr_en1    (C_we1),
    .clr_tag1   (head),
    .clr_en2    (C_we2),
    .clr_tag2   (head_p1),
    .rd_tag1    (head),
    .rd_tag2    (head_p1),
    .rd_rdy1_c  (rdy_head),
    .rd_rdy2_c  (rdy_head_p1)
  );

`ifdef ROB_STALL_CNT_EN
  // Saturating count of cycles where dispatch wanted tags but was held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (flush) begin
      stall_cnt <= '0;
    end else if (stall && (need != 2'd0) && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rob_tag_alloc.sv
// Randomized bench for rob_tag_alloc against an in-order queue model of the tag space.
module tb_rob_tag_alloc;
  import rob_tag_alloc_pkg::*;

  logic clk = 1'b0;
  logic rst, flush, alloc_req1, alloc_req2;
  logic we_INT1, we_INT2, we_MUL, we_LW;
  tag_t INT_tag1, INT_tag2, MUL_tag, LW_tag;
  tag_t new_tag1, new_tag2, C_p;
  logic stall, C_we1, C_we2;
  occ_t occ;
`ifdef ROB_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  rob_tag_alloc dut (
    .clk(clk), .rst(rst), .flush(flush),
    .alloc_req1(alloc_req1), .alloc_req2(alloc_req2),
    .new_tag1(new_tag1), .new_tag2(new_tag2), .stall(stall),
    .we_INT1(we_INT1), .we_INT2(we_INT2), .we_MUL(we_MUL), .we_LW(we_LW),
    .INT_tag1(INT_tag1), .INT_tag2(INT_tag2), .MUL_tag(MUL_tag), .LW_tag(LW_tag),
    .C_p(C_p), .C_we1(C_we1), .C_we2(C_we2), .occ(occ)
`ifdef ROB_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: in-flight tags in program order, completion flags, next free tag.
  int q[$];
  bit done_m[32];
  int tail_m;
  int scnt_m;
  bit exp_stall, exp_we1, exp_we2;
  int exp_need;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int head_m();
    return (q.size() != 0) ? q[0] : tail_m;
  endfunction

  function automatic bit is_live(input int t);
    foreach (q[i]) if (q[i] == t) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    q.delete();
    foreach (done_m[i]) done_m[i] = 1'b0;
    tail_m = 0;
    scnt_m = 0;
  endtask

  task automatic idle();
    flush = 0; alloc_req1 = 0; alloc_req2 = 0;
    we_INT1 = 0; we_INT2 = 0; we_MUL = 0; we_LW = 0;
    INT_tag1 = '0; INT_tag2 = '0; MUL_tag = '0; LW_tag = '0;
  endtask

  // Compare every DUT output against what the model says this cycle.
  task automatic check_model();
    exp_need  = int'(alloc_req1) + int'(alloc_req2);
    exp_stall = flush || ((32 - q.size()) < exp_need);
    exp_we1   = !flush && (q.size() >= 1) && done_m[q[0]];
    exp_we2   = exp_we1 && (q.size() >= 2) && done_m[q[1]];
    chk("stall", 32'(stall), 32'(exp_stall));
    chk("new_tag1", 32'(new_tag1), 32'(tail_m));
    chk("new_tag2", 32'(new_tag2), 32'((tail_m + int'(alloc_req1)) % 32));
    chk("C_p", 32'(C_p), 32'(head_m()));
    chk("C_we1", 32'(C_we1), 32'(exp_we1));
    chk("C_we2", 32'(C_we2), 32'(exp_we2));
    chk("occ", 32'(occ), 32'(q.size()));
`ifdef ROB_STALL_CNT_EN
    chk("stall_cnt", 32'(stall_cnt), 32'(scnt_m));
`endif
  endtask

  task automatic model_update();
    bit setm[32];
    int n;
    if (flush) begin
      model_reset();
      return;
    end
    if (exp_stall && exp_need > 0 && scnt_m < 65535) scnt_m++;
    foreach (setm[i]) setm[i] = 1'b0;
    if (we_INT1 && is_live(int'(INT_tag1))) setm[INT_tag1] = 1'b1;
    if (we_INT2 && is_live(int'(INT_tag2))) setm[INT_tag2] = 1'b1;
    if (we_MUL  && is_live(int'(MUL_tag)))  setm[MUL_tag]  = 1'b1;
    if (we_LW   && is_live(int'(LW_tag)))   setm[LW_tag]   = 1'b1;
    n = int'(exp_we1) + int'(exp_we2);
    repeat (n) begin
      int t;
      t = q.pop_front();
      done_m[t] = 1'b0;
      setm[t] = 1'b0;
    end
    foreach (setm[i]) if (setm[i]) done_m[i] = 1'b1;
    if (!exp_stall) begin
      if (alloc_req1) begin q.push_back(tail_m); done_m[tail_m] = 1'b0; tail_m = (tail_m + 1) % 32; end
      if (alloc_req2) begin q.push_back(tail_m); done_m[tail_m] = 1'b0; tail_m = (tail_m + 1) % 32; end
    end
  endtask

  task automatic settle();
    @(negedge clk);
    check_model();
  endtask

  task automatic advance();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    #2;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic rand_tag(output tag_t t);
    if (q.size() != 0 && ($urandom % 4) != 0) t = tag_t'(q[$urandom % q.size()]);
    else t = tag_t'($urandom % 32);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset values
    settle();
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_C_p", 32'(C_p), 32'd0);
    chk("rst_new_tag1", 32'(new_tag1), 32'd0);
    chk("rst_C_we1", 32'(C_we1), 32'd0);
    advance();

    // First dual allocation
    alloc_req1 = 1; alloc_req2 = 1;
    settle();
    chk("t1_new_tag1", 32'(new_tag1), 32'd0);
    chk("t1_new_tag2", 32'(new_tag2), 32'd1);
    chk("t1_stall", 32'(stall), 32'd0);
    advance();
    idle();
    settle();
    chk("t1_occ", 32'(occ), 32'd2);
    chk("t1_tail", 32'(new_tag1), 32'd2);
    chk("t1_C_we1", 32'(C_we1), 32'd0);
    advance();

    // Out-of-order completion, in-order double commit
    we_MUL = 1; MUL_tag = 5'd1;
    settle(); advance();
    idle(); we_INT1 = 1; INT_tag1 = 5'd0;
    settle();
    chk("t2_C_we1_early", 32'(C_we1), 32'd0);
    advance();
    idle();
    settle();
    chk("t2_C_we1", 32'(C_we1), 32'd1);
    chk("t2_C_we2", 32'(C_we2), 32'd1);
    chk("t2_C_p", 32'(C_p), 32'd0);
    advance();
    settle();
    chk("t2_occ", 32'(occ), 32'd0);
    chk("t2_head", 32'(C_p), 32'd2);
    advance();

    // Fill to 31, over-request, top off, stall while committing
    do_reset();
    for (int i = 0; i < 15; i++) begin
      alloc_req1 = 1; alloc_req2 = 1;
      settle(); advance();
    end
    alloc_req2 = 0;
    settle(); advance();
    alloc_req2 = 1;
    settle();
    chk("t3_stall_2", 32'(stall), 32'd1);
    advance();
    alloc_req2 = 0;
    settle();
    chk("t3_stall_1", 32'(stall), 32'd0);
    chk("t3_tag31", 32'(new_tag1), 32'd31);
    advance();
    idle(); we_INT1 = 1; INT_tag1 = 5'd0;
    settle(); advance();
    idle(); alloc_req1 = 1;
    settle();
    chk("t3_full_occ", 32'(occ), 32'd32);
    chk("t3_full_C_we1", 32'(C_we1), 32'd1);
    chk("t3_full_stall", 32'(stall), 32'd1);
    advance();

    // Flush with occ=5, ready head, simultaneous alloc and writeback
    do_reset();
    alloc_req1 = 1; alloc_req2 = 1;
    settle(); advance();
    settle(); advance();
    alloc_req2 = 0; we_INT1 = 1; INT_tag1 = 5'd0;
    settle(); advance();
    alloc_req1 = 1; alloc_req2 = 1; flush = 1; we_INT1 = 1; INT_tag1 = 5'd1;
    settle();
    chk("t4_pre_occ", 32'(occ), 32'd5);
    chk("t4_flush_we1", 32'(C_we1), 32'd0);
    chk("t4_flush_stall", 32'(stall), 32'd1);
    advance();
    idle();
    settle();
    chk("t4_occ", 32'(occ), 32'd0);
    chk("t4_head", 32'(C_p), 32'd0);
    chk("t4_tail", 32'(new_tag1), 32'd0);
    chk("t4_C_we1", 32'(C_we1), 32'd0);
    advance();

    // Wrap: bring head=tail=30, then allocate 30,31,0,1 and retire in order
    for (int i = 0; i < 15; i++) begin
      alloc_req1 = 1; alloc_req2 = 1;
      settle(); advance();
    end
    idle();
    for (int c = 0; c < 8; c++) begin
      we_INT1 = (4*c+0 < 30); INT_tag1 = tag_t'(4*c+0);
      we_INT2 = (4*c+1 < 30); INT_tag2 = tag_t'(4*c+1);
      we_MUL  = (4*c+2 < 30); MUL_tag  = tag_t'(4*c+2);
      we_LW   = (4*c+3 < 30); LW_tag   = tag_t'(4*c+3);
      settle(); advance();
    end
    idle();
    repeat (12) begin settle(); advance(); end
    settle();
    chk("t5_drained", 32'(occ), 32'd0);
    chk("t5_head30", 32'(C_p), 32'd30);
    advance();
    alloc_req1 = 1; alloc_req2 = 1;
    settle();
    chk("t5_tag30", 32'(new_tag1), 32'd30);
    chk("t5_tag31", 32'(new_tag2), 32'd31);
    advance();
    settle();
    chk("t5_tag0", 32'(new_tag1), 32'd0);
    chk("t5_tag1", 32'(new_tag2), 32'd1);
    advance();
    idle();
    we_INT1 = 1; INT_tag1 = 5'd30; we_INT2 = 1; INT_tag2 = 5'd31;
    we_MUL = 1; MUL_tag = 5'd0; we_LW = 1; LW_tag = 5'd1;
    settle(); advance();
    idle();
    settle();
    chk("t5_c1_we1", 32'(C_we1), 32'd1);
    chk("t5_c1_we2", 32'(C_we2), 32'd1);
    chk("t5_c1_p", 32'(C_p), 32'd30);
    advance();
    settle();
    chk("t5_c2_p", 32'(C_p), 32'd0);
    chk("t5_c2_we2", 32'(C_we2), 32'd1);
    advance();

    // Writeback to a non-live tag must not pre-complete it
    do_reset();
    we_LW = 1; LW_tag = 5'd7;
    settle(); advance();
    idle();
    for (int i = 0; i < 4; i++) begin
      alloc_req1 = 1; alloc_req2 = 1;
      settle(); advance();
    end
    idle();
    for (int i = 0; i < 7; i++) begin
      we_INT1 = 1; INT_tag1 = tag_t'(i);
      settle(); advance();
    end
    idle();
    repeat (4) begin settle(); advance(); end
    settle();
    chk("t6_head7", 32'(C_p), 32'd7);
    chk("t6_no_commit", 32'(C_we1), 32'd0);
    advance();
    we_MUL = 1; MUL_tag = 5'd7;
    settle(); advance();
    idle();
    settle();
    chk("t6_commit7", 32'(C_we1), 32'd1);
    advance();

    // Randomized phases: filling, balanced, draining
    for (int ph = 0; ph < 3; ph++) begin
      int pct;
      pct = (ph == 0) ? 8 : (ph == 1) ? 45 : 90;
      for (int c = 0; c < 1000; c++) begin
        tag_t t;
        flush      = (($urandom % 150) == 0);
        alloc_req1 = (($urandom % 100) < ((ph == 2) ? 20 : 75));
        alloc_req2 = (($urandom % 100) < ((ph == 2) ? 20 : 75));
        we_INT1 = (($urandom % 100) < pct); rand_tag(t); INT_tag1 = t;
        we_INT2 = (($urandom % 100) < pct); rand_tag(t); INT_tag2 = t;
        we_MUL  = (($urandom % 100) < pct); rand_tag(t); MUL_tag  = t;
        we_LW   = (($urandom % 100) < pct); rand_tag(t); LW_tag   = t;
        settle(); advance();
      end
    end

    // Asynchronous reset between clock edges
    idle();
    alloc_req1 = 1; alloc_req2 = 1;
    settle(); advance();
    idle();
    rst = 1'b1;
    #2;
    chk("t7_async_occ", 32'(occ), 32'd0);
    chk("t7_async_C_p", 32'(C_p), 32'd0);
    chk("t7_async_tail", 32'(new_tag1), 32'd0);
    chk("t7_async_C_we1", 32'(C_we1), 32'd0);
    rst = 1'b0;
    model_reset();
    repeat (3) begin settle(); advance(); end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
